// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: frame/line supervisor and output pixel selector placed behind a median filter.
// Ports: clk/rst_n (async active-low); cfg_* (sampled into shadows at frame start);
//        flt_* timing and flt_y/raw_y from the filter; out_* timing/pixel delayed one clock;
//        frame_done pulse, sticky line_err/frame_err, frame_cnt/err_cnt statistics.
// Build option: define MEDIAN_FRAME_CTRL_STATS_EN to implement frame_cnt/err_cnt (otherwise both read 0).
module median_frame_ctrl #(
    parameter logic [8:0] IMG_HDISP = 9'd320,
    parameter logic [7:0] IMG_VDISP = 8'd240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_filter_en,
    input  logic [1:0]  cfg_border_mode,
    input  logic [7:0]  cfg_border_val,
    input  logic        flt_vsync,
    input  logic        flt_href,
    input  logic        flt_clken,
    input  logic [7:0]  flt_y,
    input  logic [7:0]  raw_y,
    output logic        out_vsync,
    output logic        out_href,
    output logic        out_clken,
    output logic [7:0]  out_y,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);
    localparam logic [8:0] H_LAST = IMG_HDISP - 9'd1;
    localparam logic [7:0] V_LAST = IMG_VDISP - 8'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        vsync_q, href_q, clken_q;
    logic [7:0]  y_q, y_d;
    logic [8:0]  hcnt_q, hcnt_d;
    logic [7:0]  vcnt_q, vcnt_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        sh_en_q, sh_en_d;
    logic [1:0]  sh_mode_q, sh_mode_d;
    logic [7:0]  sh_val_q, sh_val_d;
    logic        vs_rise, href_fall, pix_cnt, load_shadow, is_border;

    // The delayed timing registers double as the previous-cycle values for edge detection.
    assign vs_rise   = flt_vsync & ~vsync_q;
    assign href_fall = ~flt_href & href_q;
    assign pix_cnt   = flt_href & flt_clken;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (vs_rise) state_d = SYNC;
            SYNC:    if (!vs_rise && flt_href) state_d = ACTIVE;
            ACTIVE: begin
                if (vs_rise) begin
                    state_d = SYNC;
                end else if (href_fall && (vcnt_q == V_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        frame_done = 1'b0;
        if (state_q == DONE) begin
            frame_done = 1'b1;
        end
    end

    // Counters, sticky errors and shadow loading. The first href cycle is seen
    // in SYNC, so a pixel arriving there is counted too; hcnt was cleared on SYNC entry.
    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        load_shadow = 1'b0;
        unique case (state_q)
            IDLE: load_shadow = vs_rise;
            SYNC: begin
                if (vs_rise) begin
                    load_shadow = 1'b1;
                end else if (pix_cnt) begin
                    hcnt_d = hcnt_q + 9'd1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    frame_err_d = 1'b1;
                    load_shadow = 1'b1;
                end else if (href_fall) begin
                    if (hcnt_q != IMG_HDISP) begin
                        line_err_d = 1'b1;
                    end
                    hcnt_d = '0;
                    vcnt_d = vcnt_q + 8'd1;
                end else if (pix_cnt) begin
                    hcnt_d = hcnt_q + 9'd1;
                end
            end
            default: ;
        endcase
        if (load_shadow) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    assign sh_en_d   = load_shadow ? cfg_filter_en   : sh_en_q;
    assign sh_mode_d = load_shadow ? cfg_border_mode : sh_mode_q;
    assign sh_val_d  = load_shadow ? cfg_border_val  : sh_val_q;

    // Border test uses the counts of the pixel being presented, before increment.
    assign is_border = (hcnt_q == 9'd0) || (hcnt_q == H_LAST) ||
                       (vcnt_q == 8'd0) || (vcnt_q == V_LAST);

    always_comb begin
        y_d = y_q;
        if (flt_clken) begin
            if (!sh_en_q) begin
                y_d = raw_y;
            end else if (is_border) begin
                unique case (sh_mode_q)
                    2'd0:    y_d = flt_y;
                    2'd2:    y_d = sh_val_q;
                    default: y_d = raw_y;
                endcase
            end else begin
                y_d = flt_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            clken_q     <= 1'b0;
            y_q         <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            sh_en_q     <= 1'b0;
            sh_mode_q   <= '0;
            sh_val_q    <= '0;
        end else begin
            vsync_q     <= flt_vsync;
            href_q      <= flt_href;
            clken_q     <= flt_clken;
            y_q         <= y_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            sh_en_q     <= sh_en_d;
            sh_mode_q   <= sh_mode_d;
            sh_val_q    <= sh_val_d;
        end
    end

    assign out_vsync = vsync_q;
    assign out_href  = href_q;
    assign out_clken = clken_q;
    assign out_y     = y_q;
    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;

`ifdef MEDIAN_FRAME_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_inc;

    // Only the transition of a sticky flag counts, never its steady state.
    assign err_inc     = (line_err_d & ~line_err_q) | (frame_err_d & ~frame_err_q);
    assign frame_cnt_d = (state_q == DONE) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    assign err_cnt_d   = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb_median_frame_ctrl: random-pixel frames checked every cycle against a frame-level model.
// A reduced image size keeps many frames within a short run.
module tb_median_frame_ctrl;
    localparam int H = 12;
    localparam int V = 6;
`ifdef MEDIAN_FRAME_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_filter_en;
    logic [1:0]  cfg_border_mode;
    logic [7:0]  cfg_border_val;
    logic        flt_vsync, flt_href, flt_clken;
    logic [7:0]  flt_y, raw_y;
    logic        out_vsync, out_href, out_clken;
    logic [7:0]  out_y;
    logic        frame_done, line_err, frame_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    median_frame_ctrl #(.IMG_HDISP(9'd12), .IMG_VDISP(8'd6)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_filter_en(cfg_filter_en), .cfg_border_mode(cfg_border_mode),
        .cfg_border_val(cfg_border_val),
        .flt_vsync(flt_vsync), .flt_href(flt_href), .flt_clken(flt_clken),
        .flt_y(flt_y), .raw_y(raw_y),
        .out_vsync(out_vsync), .out_href(out_href), .out_clken(out_clken), .out_y(out_y),
        .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    // Frame-level model: configuration captured at frame start plus expected status.
    logic        m_en = 1'b0;
    logic [1:0]  m_mode = 2'd0;
    logic [7:0]  m_val = 8'd0;
    bit          m_frame = 1'b0;
    logic        exp_line_err = 1'b0;
    logic        exp_frame_err = 1'b0;
    logic [15:0] exp_frame_cnt = 16'd0;
    logic [7:0]  exp_err_cnt = 8'd0;
    logic        done_window = 1'b0;
    logic [7:0]  exp_q[$];

    // Compare-process history
    logic        pv = 1'b0, ph = 1'b0, pc = 1'b0, prst = 1'b0, ok;
    logic        ev, eh, ec;
    logic [7:0]  hold_y = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int row, input int col,
                                           input logic [7:0] fy, input logic [7:0] ry);
        bit border;
        border = (row == 0) || (row == V - 1) || (col == 0) || (col == H - 1);
        if (!m_en) return ry;
        if (border) begin
            if (m_mode == 2'd0) return fy;
            if (m_mode == 2'd2) return m_val;
            return ry;
        end
        return fy;
    endfunction

    task automatic bump_err();
        if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
    endtask

    task automatic scramble_cfg();
        cfg_filter_en   = 1'($urandom_range(0, 1));
        cfg_border_mode = 2'($urandom_range(0, 3));
        cfg_border_val  = 8'($urandom_range(0, 255));
    endtask

    task automatic drive(input logic v, input logic h, input logic c,
                         input logic [7:0] fy, input logic [7:0] ry);
        @(posedge clk);
        #1;
        flt_vsync = v; flt_href = h; flt_clken = c; flt_y = fy; raw_y = ry;
    endtask

    task automatic drive_idle(input logic v);
        drive(v, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    task automatic line(input int row, input int len);
        int col;
        logic c;
        logic [7:0] fy, ry;
        col = 0;
        while (col < len) begin
            c  = ($urandom_range(0, 3) != 0);
            fy = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            scramble_cfg();
            drive(1'b0, 1'b1, c, fy, ry);
            if (c) begin
                exp_q.push_back(exp_pix(row, col, fy, ry));
                col++;
            end
        end
        drive_idle(1'b0);                 // href fall seen here
        drive_idle(1'b0);                 // flags and frame_done visible now
        if (m_frame) begin
            if (len != H && !exp_line_err) begin
                exp_line_err = 1'b1;
                bump_err();
            end
            if (row == V - 1) done_window = 1'b1;
        end
        drive_idle(1'b0);
        if (done_window) begin
            done_window   = 1'b0;
            exp_frame_cnt = exp_frame_cnt + 16'd1;
            m_frame       = 1'b0;
        end
        repeat ($urandom_range(0, 2)) drive_idle(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_en = 1'b0; m_mode = 2'd0; m_val = 8'd0; m_frame = 1'b0;
        exp_line_err = 1'b0; exp_frame_err = 1'b0;
        exp_frame_cnt = 16'd0; exp_err_cnt = 8'd0; done_window = 1'b0;
        #1;
        chk("rst_now_out_y", out_y, 8'h00);
        chk("rst_now_out_href", out_href, 1'b0);
        chk("rst_now_frame_done", frame_done, 1'b0);
        chk("rst_now_line_err", line_err, 1'b0);
        chk("rst_now_frame_cnt", frame_cnt, 16'd0);
        chk("rst_now_err_cnt", err_cnt, 8'd0);
        drive_idle(1'b0);
        drive_idle(1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_idle(1'b0);
    endtask

    task automatic frame(input logic en, input logic [1:0] mode, input logic [7:0] val,
                         input int nlines, input int short_row, input int rst_row);
        bit abort;
        cfg_filter_en = en; cfg_border_mode = mode; cfg_border_val = val;
        drive_idle(1'b1);                 // vsync rising: configuration captured
        abort   = m_frame;
        m_en    = en; m_mode = mode; m_val = val;
        m_frame = 1'b1;
        drive_idle(1'b1);
        if (abort && !exp_frame_err) begin
            exp_frame_err = 1'b1;
            bump_err();
        end
        scramble_cfg();
        drive_idle(1'b1);
        drive_idle(1'b0);
        drive_idle(1'b0);
        for (int r = 0; r < nlines; r++) begin
            if (r == rst_row) do_reset();
            line(r, (r == short_row) ? H - 1 : H);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            ok = prst && rst_n;
            ev = ok ? pv : 1'b0;
            eh = ok ? ph : 1'b0;
            ec = ok ? pc : 1'b0;
            chk("out_vsync", out_vsync, ev);
            chk("out_href", out_href, eh);
            chk("out_clken", out_clken, ec);
            if (!ok) hold_y = 8'h00;
            if (ec) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_y_unexpected actual=%0h required=no_pixel", out_y);
                end else begin
                    hold_y = exp_q.pop_front();
                    chk("out_y", out_y, hold_y);
                end
            end else begin
                chk("out_y_hold", out_y, hold_y);
            end
            chk("frame_done", frame_done, done_window);
            if (frame_done === 1'b1) done_pulses++;
            chk("line_err", line_err, exp_line_err);
            chk("frame_err", frame_err, exp_frame_err);
            chk("frame_cnt", frame_cnt, STATS ? exp_frame_cnt : 16'd0);
            chk("err_cnt", err_cnt, STATS ? exp_err_cnt : 8'd0);
            pv = flt_vsync; ph = flt_href; pc = flt_clken; prst = rst_n;
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cfg_filter_en = 1'b0; cfg_border_mode = 2'd0; cfg_border_val = 8'd0;
        flt_vsync = 1'b0; flt_href = 1'b0; flt_clken = 1'b0; flt_y = 8'd0; raw_y = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_frame_done", frame_done, 1'b0);
        chk("reset_out_y", out_y, 8'h00);
        chk("reset_frame_err", frame_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_idle(1'b0);

        // Hand-computed pins for the pixel rule
        m_en = 1'b1; m_mode = 2'd2; m_val = 8'hAA;
        chk("pin_row0", exp_pix(0, 5, 8'h11, 8'h22), 8'hAA);
        chk("pin_rowlast", exp_pix(V - 1, 5, 8'h11, 8'h22), 8'hAA);
        chk("pin_col0", exp_pix(3, 0, 8'h11, 8'h22), 8'hAA);
        chk("pin_collast", exp_pix(3, H - 1, 8'h11, 8'h22), 8'hAA);
        chk("pin_interior", exp_pix(1, 1, 8'h11, 8'h22), 8'h11);
        m_mode = 2'd3;
        chk("pin_mode3", exp_pix(0, 0, 8'h11, 8'h22), 8'h22);
        m_en = 1'b0;
        chk("pin_bypass", exp_pix(2, 2, 8'h11, 8'h22), 8'h22);

        frame(1'b1, 2'd0, 8'h00, V, -1, -1);          // filtered, border filtered
        chk("frameA_done", done_pulses, 1);
        chk("frameA_cnt", frame_cnt, STATS ? 16'd1 : 16'd0);
        frame(1'b1, 2'd2, 8'hAA, V, -1, -1);          // constant border
        frame(1'b1, 2'd1, 8'h55, V, -1, -1);          // raw border
        frame(1'b1, 2'd0, 8'h00, V, -1, -1);          // cfg toggles mid-frame
        frame(1'b0, 2'd2, 8'hAA, V, -1, -1);          // bypass
        chk("frames_done5", done_pulses, 5);
        frame(1'b1, 2'd0, 8'h00, V, 2, -1);           // one short line
        chk("short_line_err", line_err, 1'b1);
        chk("short_err_cnt", err_cnt, STATS ? 8'd1 : 8'd0);
        chk("short_frame_done", done_pulses, 6);
        frame(1'b1, 2'd0, 8'h00, 3, -1, -1);          // aborted by next vsync
        frame(1'b1, 2'd2, 8'h3C, V, -1, -1);
        chk("abort_frame_err", frame_err, 1'b1);
        chk("abort_err_cnt", err_cnt, STATS ? 8'd2 : 8'd0);
        chk("abort_done", done_pulses, 7);
        chk("abort_frame_cnt", frame_cnt, STATS ? 16'd7 : 16'd0);
        frame(1'b1, 2'd2, 8'hAA, V, 4, 2);            // reset mid-frame
        chk("rst_no_done", done_pulses, 7);
        chk("rst_line_err", line_err, 1'b0);
        frame(1'b1, 2'd0, 8'h00, V, -1, -1);
        chk("after_rst_cnt", frame_cnt, STATS ? 16'd1 : 16'd0);
        chk("after_rst_done", done_pulses, 8);

        repeat (6) begin
            frame(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  V, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, V - 1)) : -1, -1);
        end
        repeat (3) drive_idle(1'b0);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/median_frame_ctrl.md
MEDIAN_FRAME_CTRL -- requirements
Module: median_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_HDISP, 9'd320, active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, 8'd240, active lines per frame.
REQ-003 SHALL have port clk  input  1  pixel clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_filter_en  input  1  1 = median output, 0 = raw bypass.
REQ-006 SHALL have port cfg_border_mode  input  2  border pixel source: 0 filtered, 1 raw, 2 constant, 3 raw.
REQ-007 SHALL have port cfg_border_val  input  8  constant for border_mode 2.
REQ-008 SHALL have ports flt_vsync, flt_href, flt_clken  input  1 each  filter output timing, active-high.
REQ-009 SHALL have port flt_y  input  8  median filter result, aligned to flt_clken.
REQ-010 SHALL have port raw_y  input  8  unfiltered centre pixel, aligned to flt_clken.
REQ-011 SHALL have ports out_vsync, out_href, out_clken  output  1 each  timing delayed by one clock.
REQ-012 SHALL have port out_y  output  8  selected pixel.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.
REQ-014 SHALL have port line_err  output  1  sticky, line length not equal to IMG_HDISP.
REQ-015 SHALL have port frame_err  output  1  sticky, vsync rising before IMG_VDISP lines.
REQ-016 SHALL have ports frame_cnt  output  16 and err_cnt  output  8  statistics.

Function
REQ-017 SHALL implement FSM states IDLE, SYNC, ACTIVE, DONE; reset state IDLE.
REQ-018 IDLE -> SYNC on flt_vsync rising edge (1 in current cycle, 0 in previous).
REQ-019 On entry to SYNC, cfg_filter_en, cfg_border_mode, cfg_border_val SHALL be copied to shadow registers; shadows are otherwise constant.
REQ-020 SYNC -> ACTIVE on first cycle with flt_href=1; hcnt=0, vcnt=0.
REQ-021 In ACTIVE, hcnt (9 bit) SHALL increment on each flt_clken while flt_href=1.
REQ-022 On flt_href falling edge: if hcnt != IMG_HDISP set line_err; clear hcnt; increment vcnt (8 bit).
REQ-023 When vcnt reaches IMG_VDISP, ACTIVE -> DONE; DONE asserts frame_done for exactly one cycle, then -> IDLE.
REQ-024 flt_vsync rising edge in ACTIVE SHALL set frame_err, increment err_cnt, reload shadows, clear counters, go to SYNC (no frame_done).
REQ-025 line_err and frame_err increment err_cnt when each is newly set; err_cnt saturates at 255.
REQ-026 A pixel is border when hcnt==0, hcnt==IMG_HDISP-1, vcnt==0 or vcnt==IMG_VDISP-1 (counts before increment).
REQ-027 out_y SHALL be registered: shadow filter_en=0 -> raw_y; else border -> per shadow mode (0 flt_y, 1/3 raw_y, 2 border_val); else flt_y.
REQ-028 out_y updates only when flt_clken=1; holds otherwise.
REQ-029 out_vsync/out_href/out_clken SHALL equal the flt_ inputs delayed by exactly one clock, all states.
REQ-030 Latency flt_y/raw_y -> out_y SHALL be exactly one clock, aligned to out_clken.
REQ-031 frame_cnt SHALL increment in DONE, wrapping 0xFFFF -> 0.
REQ-032 Cfg changes outside SYNC entry SHALL not affect the current frame.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, all counters 0, out_* 0, frame_done 0, line_err 0, frame_err 0, frame_cnt 0, err_cnt 0, shadows 0 (bypass).
REQ-034 Reset mid-frame SHALL discard the frame; resumes only at next vsync rising edge after release.
REQ-035 Sticky errors SHALL clear only by reset.

Configuration
REQ-036 Macro MEDIAN_FRAME_CTRL_STATS_EN defined: frame_cnt and err_cnt implemented per REQ-025/031.
REQ-037 Macro undefined: frame_cnt and err_cnt tied to 0, counter registers removed; all other behaviour identical.

Verification
REQ-038 filter_en=1, mode=0, full 320x240 frame -> out_y==flt_y every pixel, one clock late; one frame_done pulse; frame_cnt=1.
REQ-039 filter_en=1, mode=2, val=8'hAA -> row 0, row 239, col 0, col 319 out_y=8'hAA; interior (1,1) out_y=flt_y.
REQ-040 filter_en toggled 1->0 mid-frame -> frame fully filtered; next frame out_y==raw_y.
REQ-041 Line of 319 pixels -> line_err=1 after that href fall, err_cnt=1, frame still completes with frame_done.
REQ-042 vsync rising after 100 lines -> frame_err=1, no frame_done, next full frame gives frame_done, frame_cnt=1.
REQ-043 rst_n low at line 50 -> all outputs 0 same cycle; after release, no output activity changes state until vsync rising edge.
